// File: rtl/hdbn_if.sv
// hdbn_if: the symbol-stream bundle between the bit source, the HDBn
// substitutor and the downstream polarity stage.
//
// Handshake: a transfer happens on every rising clock edge where in_valid=1;
// there is no ready signal, so the substitutor accepts every valid beat.
// out_valid is a one-cycle strobe and the consumer must take out_sym on
// every cycle where it is high, because there is no back-pressure.
//
// Signals:
//   in_valid  source -> substitutor  input strobe, one accept per high cycle
//   in_bit    source -> substitutor  NRZ data bit
//   sub_en    source -> substitutor  1 = substitution on, 0 = pass-through
//   out_valid substitutor -> sink    one-cycle strobe per emitted symbol
//   out_sym   substitutor -> sink    00 zero, 01 mark, 11 V, 10 B
interface hdbn_if;
  logic       in_valid;
  logic       in_bit;
  logic       sub_en;
  logic       out_valid;
  logic [1:0] out_sym;

  modport master (
    output in_valid,
    output in_bit,
    output sub_en,
    input  out_valid,
    input  out_sym
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  sub_en,
    output out_valid,
    output out_sym
  );
endinterface

// File: rtl/hdbn_substitutor.sv
// hdbn_substitutor: parametrised HDBn zero-substitution stage.
//
// Turns an NRZ bit stream into 2-bit HDB symbols with the V and B pulses
// already in place. A run of ZMAX+1 zeros is replaced by B0..0V when an even
// number of marks has been sent since the last V, and by 0..0V otherwise.
// Symbols pass through a DEPTH = ZMAX+1 stage delay line so that the B can be
// written back over the first zero of the run before that zero is emitted.
// ZMAX=3 gives HDB3, ZMAX=2 gives HDB2/B3ZS. Legal ZMAX range is 1..15.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, takes priority over an accept
//   bus  hdbn_if slave modport (in_valid, in_bit, sub_en, out_valid, out_sym)
module hdbn_substitutor #(
  parameter int ZMAX = 3
) (
  input  logic   clk,
  input  logic   rst,
  hdbn_if.slave  bus
);

  localparam int DEPTH = ZMAX + 1;
  localparam int ZW    = $clog2(ZMAX + 1);
  localparam int FW    = $clog2(DEPTH + 1);

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_MARK = 2'b01;
  localparam logic [1:0] SYM_V    = 2'b11;
  localparam logic [1:0] SYM_B    = 2'b10;

  logic [1:0]    d_q [DEPTH];
  logic [FW-1:0] fill_q;
  logic [ZW-1:0] zcnt_q;
  logic [ZW-1:0] zcnt_d;
  logic          par_q;
  logic          par_d;
  logic [1:0]    new_sym;
  logic          set_b;
  logic          out_valid_q;
  logic [1:0]    out_sym_q;

  // Classify the incoming bit. A zero seen with sub_en=0 clears the run
  // counter, so a run straddling an enable change only counts enabled zeros.
  always_comb begin
    new_sym = SYM_ZERO;
    zcnt_d  = '0;
    par_d   = par_q;
    set_b   = 1'b0;
    if (bus.in_bit) begin
      new_sym = SYM_MARK;
      par_d   = ~par_q;
    end else if (bus.sub_en) begin
      if (zcnt_q == ZW'(ZMAX)) begin
        // Substitution event: V now, and B on the first zero of the run
        // only when the mark count since the last V is even.
        new_sym = SYM_V;
        set_b   = ~par_q;
        par_d   = 1'b0;
      end else begin
        zcnt_d = zcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) d_q[i] <= SYM_ZERO;
      fill_q      <= '0;
      zcnt_q      <= '0;
      par_q       <= 1'b0;
      out_sym_q   <= SYM_ZERO;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      out_sym_q   <= d_q[DEPTH-1];
      out_valid_q <= (fill_q == FW'(DEPTH));
      if (fill_q != FW'(DEPTH)) fill_q <= fill_q + 1'b1;
      for (int i = 1; i < DEPTH; i++) d_q[i] <= d_q[i-1];
      d_q[0] <= new_sym;
      // The first zero of the run has just shifted into the last stage;
      // this later assignment overrides the plain shift for that stage.
      if (set_b) d_q[DEPTH-1] <= SYM_B;
      zcnt_q <= zcnt_d;
      par_q  <= par_d;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;

endmodule

// File: tb/tb_hdbn_substitutor.sv
module tb_hdbn_substitutor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hdbn_if if3 ();
  hdbn_if if2 ();

  hdbn_substitutor #(.ZMAX(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  hdbn_substitutor #(.ZMAX(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Reference model: whole symbol stream since reset, per instance
  // (0: ZMAX=3, 1: ZMAX=2). A substitution rewrites earlier entries.
  logic [1:0] msym [2][0:8191];
  int         acc_n [2];
  int         zc [2];
  bit         par [2];
  logic [1:0] last_out [2];

  // Observed emitted symbols, for checks against literal sequences.
  logic [1:0] cap3 [$];
  logic [1:0] cap2 [$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int zmax_of(input int u);
    return (u == 0) ? 3 : 2;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      acc_n[u]    = 0;
      zc[u]       = 0;
      par[u]      = 1'b0;
      last_out[u] = 2'b00;
    end
    cap3.delete();
    cap2.delete();
  endtask

  // One accepted bit, straight from the substitution rules.
  task automatic model_accept(input int u, input bit b, input bit se,
                              output logic exp_v, output logic [1:0] exp_s);
    int m;
    int z;
    logic [1:0] s;
    m = acc_n[u];
    z = zmax_of(u);
    if (b) begin
      s = 2'b01; zc[u] = 0; par[u] = !par[u];
    end else if (se && zc[u] < z) begin
      s = 2'b00; zc[u]++;
    end else if (se) begin
      s = 2'b11;
      if (!par[u]) msym[u][m-z] = 2'b10;
      zc[u] = 0; par[u] = 1'b0;
    end else begin
      s = 2'b00; zc[u] = 0;
    end
    msym[u][m] = s;
    acc_n[u]   = m + 1;
    exp_v = (m >= z + 1);
    exp_s = exp_v ? msym[u][m-z-1] : 2'b00;
    last_out[u] = exp_s;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input bit b, input bit se);
    logic       ev;
    logic [1:0] es;
    @(negedge clk);
    if3.in_valid = v; if3.in_bit = b; if3.sub_en = se;
    if2.in_valid = v; if2.in_bit = b; if2.sub_en = se;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      if (v) model_accept(u, b, se, ev, es);
      else begin ev = 1'b0; es = last_out[u]; end
      if (u == 0) begin
        check("valid_z3", 8'(if3.out_valid), 8'(ev));
        check("sym_z3", 8'(if3.out_sym), 8'(es));
        if (if3.out_valid) cap3.push_back(if3.out_sym);
      end else begin
        check("valid_z2", 8'(if2.out_valid), 8'(ev));
        check("sym_z2", 8'(if2.out_sym), 8'(es));
        if (if2.out_valid) cap2.push_back(if2.out_sym);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    // in_valid may be high here: reset must win over the accept.
    if3.in_valid = 1'($urandom_range(1)); if3.in_bit = 1'($urandom_range(1)); if3.sub_en = 1'b1;
    if2.in_valid = if3.in_valid;           if2.in_bit = if3.in_bit;            if2.sub_en = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_valid_z3", 8'(if3.out_valid), 8'd0);
    check("rst_sym_z3", 8'(if3.out_sym), 8'd0);
    check("rst_valid_z2", 8'(if2.out_valid), 8'd0);
    check("rst_sym_z2", 8'(if2.out_sym), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    if3.in_valid = 1'b0;
    if2.in_valid = 1'b0;
  endtask

  // Send n bits of pat, MSB first; idle_pct gives the chance of an idle
  // cycle before each accept.
  task automatic send(input logic [31:0] pat, input int n, input bit se, input int idle_pct);
    for (int i = n - 1; i >= 0; i--) begin
      if (idle_pct > 0 && $urandom_range(99) < idle_pct)
        step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      step(1'b1, pat[i], se);
    end
  endtask

  // Compare the first n captured symbols with a literal sequence (MSB first).
  task automatic check_seq(input string tag, input int u, input logic [31:0] exp, input int n);
    logic [7:0] obs;
    for (int i = 0; i < n; i++) begin
      if (u == 0) obs = (i < cap3.size()) ? 8'(cap3[i]) : 8'hFF;
      else        obs = (i < cap2.size()) ? 8'(cap2[i]) : 8'hFF;
      check(tag, obs, 8'(exp[2*(n-1-i) +: 2]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    if3.in_valid = 1'b0; if3.in_bit = 1'b0; if3.sub_en = 1'b1;
    if2.in_valid = 1'b0; if2.in_bit = 1'b0; if2.sub_en = 1'b1;
    model_reset();

    // 0000 then padding marks: B00V
    do_reset();
    send(32'b0000, 4, 1'b1, 0);
    send(32'b1111, 4, 1'b1, 0);
    check_seq("b00v", 0, 32'b10_00_00_11, 4);

    // Odd parity before the run: 000V, no B
    do_reset();
    send(32'b1_0000_1111, 9, 1'b1, 0);
    send(32'b1111, 4, 1'b1, 0);
    check_seq("odd_000v", 0, 32'b01_00_00_00_11_01, 6);

    // Even parity, then back-to-back events
    do_reset();
    send(32'b110000, 6, 1'b1, 0);
    send(32'b00000000, 8, 1'b1, 0);
    send(32'b1111, 4, 1'b1, 0);
    check_seq("even_b00v", 0, 32'b01_01_10_00_00_11_10_00_00_11_10_00_00_11, 14);

    // Same stream with idle cycles mixed in
    do_reset();
    send(32'b110000, 6, 1'b1, 50);
    send(32'b00000000, 8, 1'b1, 50);
    send(32'b1111, 4, 1'b1, 50);
    check_seq("gaps_b00v", 0, 32'b01_01_10_00_00_11_10_00_00_11_10_00_00_11, 14);
    check("gaps_count", 8'(cap3.size()), 8'd14);

    // Pass-through: no V/B
    do_reset();
    send(32'b00000000, 8, 1'b0, 0);
    send(32'b1111, 4, 1'b0, 0);
    check_seq("passthru", 0, 32'h0, 8);

    // Reset mid-run, then a fresh run substitutes with B
    do_reset();
    send(32'b00, 2, 1'b1, 0);
    do_reset();
    send(32'b0000, 4, 1'b1, 0);
    send(32'b1111, 4, 1'b1, 0);
    check_seq("rst_midrun", 0, 32'b10_00_00_11, 4);

    // HDB2 instance
    do_reset();
    send(32'b000_11_000, 8, 1'b1, 0);
    send(32'b111, 3, 1'b1, 0);
    check_seq("hdb2", 1, 32'b10_00_11_01_01_10_00_11, 8);

    // Randomised segments: zero-heavy data, occasional sub_en flips and gaps
    for (int seg = 0; seg < 6; seg++) begin
      bit se;
      se = 1'b1;
      do_reset();
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(99) < 5) se = !se;
        if ($urandom_range(99) < 25)
          step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        step(1'b1, ($urandom_range(99) < 30), se);
      end
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hdbn_substitutor.md
# hdbn_substitutor

Parametrised HDBn zero-substitution stage. It takes a binary NRZ bit stream and emits the 2-bit HDB symbol stream with V and B pulses already inserted. Zero runs longer than ZMAX are replaced by B0..0V or 0..0V, depending on the mark parity since the last V. It sits between the bit source and the polarity (AMI) alternation stage, and supersedes the fixed HDB3 add-V/add-B pair. ZMAX=3 gives HDB3 and ZMAX=2 gives HDB2/B3ZS.

## Interface
Parameters:
- ZMAX, default 3: maximum number of consecutive zeros allowed on the line. Legal range is 1..15. The substitution string is ZMAX+1 symbols long.
- DEPTH: derived, ZMAX+1. Number of delay-line stages; not user-overridable.

Ports:
- clk  input  1: single clock, rising edge.
- rst  input  1: synchronous, active-high reset.
- in_valid  input  1: input strobe; each cycle with in_valid=1 is one accept.
- in_bit  input  1: NRZ data bit.
- sub_en  input  1: 1 = substitution on; 0 = plain pass-through. Sampled on each accept.
- out_valid  output  1: registered; high for one cycle after each accept that pushes a symbol out.
- out_sym  output  2: registered symbol code: 00 = zero, 01 = mark, 11 = V, 10 = B.

## Operation
State held by the block:
- Delay line d[0..DEPTH-1], 2-bit symbols; d[0] is the newest.
- fill: 0..DEPTH, saturating.
- zcnt: 0..ZMAX, the current zero-run length, clog2(ZMAX+1) bits.
- par: 1 bit, parity of marks accepted since the last V.

Per accept (in_valid=1), all updates on the same edge:
- out_sym <= pre-shift d[DEPTH-1]; out_valid <= (fill==DEPTH); fill increments and saturates at DEPTH.
- Shift: d[i] <= d[i-1]; d[0] <= the new symbol.
- in_bit=1: new symbol 01; zcnt <= 0; par toggles.
- in_bit=0, sub_en=1, zcnt<ZMAX: new symbol 00; zcnt increments.
- in_bit=0, sub_en=1, zcnt==ZMAX (substitution event):
  - New symbol is 11 (V).
  - If par==0, post-shift d[DEPTH-1] (the first zero of the run) is overwritten with 10 (B).
  - If par==1, no B is inserted.
  - zcnt <= 0; par <= 0.
- sub_en=0: new symbol 00 or 01 as in_bit; zcnt <= 0; par still toggles on marks.
- A B never needs to reach a symbol already emitted. The first zero of the run is always in d[DEPTH-1] at the event.
- Consecutive events (e.g. 2·(ZMAX+1) zeros): the second event sees par=0 and therefore also inserts B.

Cycles with in_valid=0:
- d, fill, zcnt, par and out_sym hold; out_valid <= 0.

Reset:
- d[*]=00, fill=0, zcnt=0, par=0, out_sym=00, out_valid=0.
- Reset mid-stream discards all buffered symbols and counters with no partial output. The first substitution after reset uses B (par=0).

Simultaneous events:
- rst has priority over in_valid.
- A sub_en change takes effect on the accept where it is sampled. A zero run straddling a change counts only zeros accepted with sub_en=1.

## Timing
- Latency: symbol k (the k-th accept after reset, from 0) appears on out_sym one cycle after the accept of symbol k+DEPTH.
- With continuous in_valid this is DEPTH+1 clocks.
- out_valid never asserts before DEPTH+1 accepts after reset.
- Throughput: one symbol per clock. There is no back-pressure; the downstream stage must consume every out_valid cycle.
- out_sym is stable while out_valid=0.

## Test plan
ZMAX=3, continuous in_valid unless stated.
- Reset, then 0000 followed by padding 1s: out_sym sequence 10,00,00,11 (B00V), then 01s.
- Input 1,0000,1111: out 01,00,00,00,11,01… (odd parity gives 000V, no B).
- Input 1,1,0000: out 01,01,10,00,00,11; input 00000000: out 10,00,00,11,10,00,00,11.
- Repeat the 1,1,0000 case with in_valid low on random cycles (about 50%):
  - Identical symbol sequence.
  - out_valid pulses only on the cycle after accepts, count equal to accepts minus DEPTH.
  - out_sym holds between pulses.
- sub_en=0 with 00000000: all 00 out, no 11/10. Assert rst after 2 zeros of a run, then send 0000+pad: out_valid low for the first DEPTH accepts, then 10,00,00,11.
- ZMAX=2 instance, reset then 000,1,1,000: out 10,00,11,01,01,10,00,11.
